// File: rtl/rsa_cmd_ctrl_if.sv
// rsa_cmd_ctrl_if: ARM command/data bus plus Montgomery core operand/result bus for rsa_cmd_ctrl
// Ports (slave = controller side):
//   arm_to_fpga_cmd[31:0], arm_to_fpga_cmd_valid   command word (opcode in [3:0]) and strobe
//   fpga_to_arm_done, fpga_to_arm_done_read        completion flag and its acknowledge
//   arm_to_fpga_data*                              1024-bit inbound valid/ready/data
//   fpga_to_arm_data*                              1024-bit outbound valid/ready/data
//   mont_start, mont_a/b/m, mont_done, mont_result Montgomery core control and operands
//   leds[3:0]                                      [2:0] state code, [3] timeout error
interface rsa_cmd_ctrl_if;
  logic [31:0]   arm_to_fpga_cmd;
  logic          arm_to_fpga_cmd_valid;
  logic          fpga_to_arm_done;
  logic          fpga_to_arm_done_read;
  logic          arm_to_fpga_data_valid;
  logic          arm_to_fpga_data_ready;
  logic [1023:0] arm_to_fpga_data;
  logic          fpga_to_arm_data_valid;
  logic          fpga_to_arm_data_ready;
  logic [1023:0] fpga_to_arm_data;
  logic          mont_start;
  logic [511:0]  mont_a;
  logic [511:0]  mont_b;
  logic [511:0]  mont_m;
  logic          mont_done;
  logic [511:0]  mont_result;
  logic [3:0]    leds;
  modport slave (
    input  arm_to_fpga_cmd, arm_to_fpga_cmd_valid, fpga_to_arm_done_read,
           arm_to_fpga_data_valid, arm_to_fpga_data, fpga_to_arm_data_ready,
           mont_done, mont_result,
    output fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid,
           fpga_to_arm_data, mont_start, mont_a, mont_b, mont_m, leds
  );
  modport master (
    output arm_to_fpga_cmd, arm_to_fpga_cmd_valid, fpga_to_arm_done_read,
           arm_to_fpga_data_valid, arm_to_fpga_data, fpga_to_arm_data_ready,
           mont_done, mont_result,
    input  fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid,
           fpga_to_arm_data, mont_start, mont_a, mont_b, mont_m, leds
  );
endinterface

// File: rtl/rsa_cmd_ctrl.sv
// rsa_cmd_ctrl: command FSM that loads RSA operands, launches the Montgomery core and returns its result
// Ports:
//   clk     system clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     rsa_cmd_ctrl_if.slave (ARM command/data handshakes, Montgomery core bus, leds)
// Optional feature: define MONT_TIMEOUT_EN to abort COMPUTE after 4095 cycles without mont_done
// and flag the abort on leds[3]; otherwise COMPUTE waits forever and leds[3] is tied 0.
module rsa_cmd_ctrl (
  input logic           clk,
  input logic           resetn,
  rsa_cmd_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX      = 3'd1,
    COMPUTE = 3'd2,
    TX      = 3'd3,
    DONE    = 3'd4
  } state_t;
  state_t       state;
  logic [3:0]   op;
  logic [511:0] result;
`ifdef MONT_TIMEOUT_EN
  logic         err;
  logic [11:0]  cnt;
  assign bus.leds = {err, state};
`else
  assign bus.leds = {1'b0, state};
`endif
  // Result only changes in COMPUTE, so the outbound word is stable for the whole TX phase.
  assign bus.fpga_to_arm_data = {512'b0, result};
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state                      <= IDLE;
      op                         <= '0;
      result                     <= '0;
      bus.fpga_to_arm_done       <= 1'b0;
      bus.arm_to_fpga_data_ready <= 1'b0;
      bus.fpga_to_arm_data_valid <= 1'b0;
      bus.mont_start             <= 1'b0;
      bus.mont_a                 <= '0;
      bus.mont_b                 <= '0;
      bus.mont_m                 <= '0;
`ifdef MONT_TIMEOUT_EN
      err                        <= 1'b0;
      cnt                        <= '0;
`endif
    end else begin
      bus.mont_start <= 1'b0;
      case (state)
        IDLE:
          if (bus.arm_to_fpga_cmd_valid) begin
            op <= bus.arm_to_fpga_cmd[3:0];
`ifdef MONT_TIMEOUT_EN
            err <= 1'b0;
`endif
            case (bus.arm_to_fpga_cmd[3:0])
              4'h1, 4'h2: begin
                state                      <= RX;
                bus.arm_to_fpga_data_ready <= 1'b1;
              end
              4'h4: begin
                state          <= COMPUTE;
                bus.mont_start <= 1'b1;
`ifdef MONT_TIMEOUT_EN
                cnt            <= '0;
`endif
              end
              4'h8: begin
                state                      <= TX;
                bus.fpga_to_arm_data_valid <= 1'b1;
              end
              default: begin
                state                <= DONE;
                bus.fpga_to_arm_done <= 1'b1;
              end
            endcase
          end
        RX:
          if (bus.arm_to_fpga_data_valid) begin
            if (op == 4'h1) begin
              bus.mont_a <= bus.arm_to_fpga_data[1023:512];
              bus.mont_b <= bus.arm_to_fpga_data[511:0];
            end else begin
              bus.mont_m <= bus.arm_to_fpga_data[511:0];
            end
            bus.arm_to_fpga_data_ready <= 1'b0;
            bus.fpga_to_arm_done       <= 1'b1;
            state                      <= DONE;
          end
        COMPUTE:
          if (bus.mont_done) begin
            result               <= bus.mont_result;
            bus.fpga_to_arm_done <= 1'b1;
            state                <= DONE;
          end
`ifdef MONT_TIMEOUT_EN
          // cnt holds the number of COMPUTE cycles already elapsed; 4094 means this is the 4095th.
          else if (cnt == 12'd4094) begin
            err                  <= 1'b1;
            bus.fpga_to_arm_done <= 1'b1;
            state                <= DONE;
          end else begin
            cnt <= cnt + 12'd1;
          end
`endif
        TX:
          if (bus.fpga_to_arm_data_ready) begin
            bus.fpga_to_arm_data_valid <= 1'b0;
            bus.fpga_to_arm_done       <= 1'b1;
            state                      <= DONE;
          end
        DONE:
          if (bus.fpga_to_arm_done_read) begin
            bus.fpga_to_arm_done <= 1'b0;
            state                <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_cmd_ctrl.sv
// tb_rsa_cmd_ctrl: directed scoreboard bench for rsa_cmd_ctrl
module tb_rsa_cmd_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  rsa_cmd_ctrl_if bus();
  rsa_cmd_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));
  typedef struct {
    logic [511:0] a;
    logic [511:0] b;
    logic [511:0] m;
    logic [3:0]   leds;
  } exp_t;
  exp_t         q[$];
  logic [511:0] txq[$];
  exp_t         e;
  logic [511:0] tx_e;
  logic [511:0] a_e, b_e, m_e, r_e;
  logic [1023:0] din;
  int passed = 0;
  int total = 0;
  int start_cnt = 0;
  int s0;
  int n;
  logic prev_done = 1'b0;
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_cmd(input logic [3:0] opc);
    bus.arm_to_fpga_cmd = {28'h0, opc};
    bus.arm_to_fpga_cmd_valid = 1'b1;
    tick();
    bus.arm_to_fpga_cmd_valid = 1'b0;
  endtask
  task automatic ack();
    bus.fpga_to_arm_done_read = 1'b1;
    tick();
    bus.fpga_to_arm_done_read = 1'b0;
  endtask
  task automatic push_exp(input logic [3:0] l);
    exp_t x;
    x.a = a_e;
    x.b = b_e;
    x.m = m_e;
    x.leds = l;
    q.push_back(x);
  endtask
  task automatic rx_data(input logic [1023:0] d);
    bus.arm_to_fpga_data = d;
    bus.arm_to_fpga_data_valid = 1'b1;
    tick();
    bus.arm_to_fpga_data_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (bus.fpga_to_arm_done && !prev_done) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        e = q.pop_front();
        chk("sb_mont_a", bus.mont_a, e.a);
        chk("sb_mont_b", bus.mont_b, e.b);
        chk("sb_mont_m", bus.mont_m, e.m);
        chk("sb_leds", {508'h0, bus.leds}, {508'h0, e.leds});
      end
    end
    if (bus.fpga_to_arm_data_valid && bus.fpga_to_arm_data_ready) begin
      if (txq.size() == 0) begin
        total++;
        $display("FAIL unexpected_tx: got transfer expected none");
      end else begin
        tx_e = txq.pop_front();
        chk("sb_tx_lo", bus.fpga_to_arm_data[511:0], tx_e);
        chk("sb_tx_hi", bus.fpga_to_arm_data[1023:512], 512'h0);
      end
    end
    if (bus.mont_start) start_cnt++;
    prev_done = bus.fpga_to_arm_done;
  end
  initial begin
    bus.arm_to_fpga_cmd = '0;
    bus.arm_to_fpga_cmd_valid = 1'b0;
    bus.fpga_to_arm_done_read = 1'b0;
    bus.arm_to_fpga_data_valid = 1'b0;
    bus.arm_to_fpga_data = '0;
    bus.fpga_to_arm_data_ready = 1'b0;
    bus.mont_done = 1'b0;
    bus.mont_result = '0;
    repeat (2) tick();
    chk("rst_done", bus.fpga_to_arm_done, 0);
    chk("rst_ready", bus.arm_to_fpga_data_ready, 0);
    chk("rst_valid", bus.fpga_to_arm_data_valid, 0);
    chk("rst_start", bus.mont_start, 0);
    chk("rst_leds", bus.leds, 0);
    chk("rst_mont_a", bus.mont_a, 0);
    chk("rst_data", bus.fpga_to_arm_data[511:0], 0);
    resetn = 1'b1;
    tick();
    // load A and B
    a_e = {16{32'hA5A5A5A5}};
    b_e = {16{32'h3C3C3C3C}};
    m_e = '0;
    push_exp(4'h4);
    send_cmd(4'h1);
    chk("rx_ready", bus.arm_to_fpga_data_ready, 1);
    chk("rx_leds", bus.leds, 1);
    tick();
    chk("rx_ready_wait", bus.arm_to_fpga_data_ready, 1);
    rx_data({a_e, b_e});
    chk("rx_latency", bus.fpga_to_arm_done, 1);
    chk("rx_ready_off", bus.arm_to_fpga_data_ready, 0);
    tick();
    chk("done_held", bus.fpga_to_arm_done, 1);
    ack();
    chk("idle_after_ack", bus.leds, 0);
    chk("done_cleared", bus.fpga_to_arm_done, 0);
    // load M
    din = {16{64'hF8F6_1234_ABCD_997D}};
    m_e = din[511:0];
    push_exp(4'h4);
    send_cmd(4'h2);
    rx_data(din);
    chk("rx2_latency", bus.fpga_to_arm_done, 1);
    ack();
    // compute, core answers after 20 cycles
    r_e = 512'h1234;
    push_exp(4'h4);
    s0 = start_cnt;
    send_cmd(4'h4);
    chk("cmp_start", bus.mont_start, 1);
    chk("cmp_leds", bus.leds, 2);
    repeat (19) tick();
    chk("cmp_no_done", bus.fpga_to_arm_done, 0);
    bus.mont_done = 1'b1;
    bus.mont_result = r_e;
    tick();
    bus.mont_done = 1'b0;
    chk("cmp_latency", bus.fpga_to_arm_done, 1);
    chk("cmp_start_pulses", start_cnt - s0, 1);
    ack();
    // stray mont_done in IDLE must not touch the result
    bus.mont_done = 1'b1;
    bus.mont_result = 512'hDEAD;
    tick();
    bus.mont_done = 1'b0;
    chk("stray_done_state", bus.leds, 0);
    chk("stray_done_flag", bus.fpga_to_arm_done, 0);
    // transmit with receiver stalled for 5 cycles
    push_exp(4'h4);
    txq.push_back(r_e);
    send_cmd(4'h8);
    for (int i = 0; i < 5; i++) begin
      chk("tx_valid_stall", bus.fpga_to_arm_data_valid, 1);
      chk("tx_data_stable", bus.fpga_to_arm_data[511:0], r_e);
      tick();
    end
    bus.fpga_to_arm_data_ready = 1'b1;
    tick();
    bus.fpga_to_arm_data_ready = 1'b0;
    chk("tx_done", bus.fpga_to_arm_done, 1);
    chk("tx_valid_off", bus.fpga_to_arm_data_valid, 0);
    ack();
    // unknown opcode, and commands ignored while in DONE
    push_exp(4'h4);
    send_cmd(4'h9);
    chk("unk_done", bus.fpga_to_arm_done, 1);
    send_cmd(4'h1);
    chk("done_ignores_cmd", bus.leds, 4);
    chk("done_no_ready", bus.arm_to_fpga_data_ready, 0);
    ack();
    // command during COMPUTE ignored, then reset aborts
    s0 = start_cnt;
    send_cmd(4'h4);
    repeat (3) tick();
    send_cmd(4'h4);
    send_cmd(4'h1);
    chk("cmp_ignores_cmd", bus.leds, 2);
    chk("cmp_single_start", start_cnt - s0, 1);
    #3 resetn = 1'b0;
    #1;
    chk("abort_leds", bus.leds, 0);
    chk("abort_done", bus.fpga_to_arm_done, 0);
    chk("abort_start", bus.mont_start, 0);
    chk("abort_mont_a", bus.mont_a, 0);
    chk("abort_mont_b", bus.mont_b, 0);
    chk("abort_mont_m", bus.mont_m, 0);
    chk("abort_result", bus.fpga_to_arm_data[511:0], 0);
    repeat (2) tick();
    resetn = 1'b1;
    a_e = '0;
    b_e = '0;
    m_e = '0;
    tick();
    chk("post_abort_idle", bus.leds, 0);
    // reset in the middle of TX
    send_cmd(4'h8);
    chk("tx2_valid", bus.fpga_to_arm_data_valid, 1);
    #3 resetn = 1'b0;
    #1;
    chk("tx_abort_valid", bus.fpga_to_arm_data_valid, 0);
    chk("tx_abort_leds", bus.leds, 0);
    tick();
    resetn = 1'b1;
    tick();
`ifdef MONT_TIMEOUT_EN
    push_exp(4'hC);
    send_cmd(4'h4);
    n = 0;
    while (!bus.fpga_to_arm_done && n < 5000) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 4095);
    chk("to_err", bus.leds[3], 1);
    ack();
    chk("to_err_held", bus.leds, 4'h8);
    push_exp(4'h4);
    send_cmd(4'h9);
    chk("to_err_cleared", bus.leds[3], 0);
    ack();
`endif
    repeat (3) tick();
    chk("sb_done_drained", q.size(), 0);
    chk("sb_tx_drained", txq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rsa_cmd_ctrl.md
RSA_CMD_CTRL -- requirements
Module: rsa_cmd_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  system clock; all state changes on rising edge
- resetn  in  1  asynchronous active-low reset
- arm_to_fpga_cmd  in  32  command word; bits [3:0] are the opcode
- arm_to_fpga_cmd_valid  in  1  command strobe
- fpga_to_arm_done  out  1  command completed
- fpga_to_arm_done_read  in  1  acknowledge of done
- arm_to_fpga_data_valid  in  1  inbound data valid
- arm_to_fpga_data_ready  out  1  inbound data ready
- arm_to_fpga_data  in  1024  inbound data
- fpga_to_arm_data_valid  out  1  outbound data valid
- fpga_to_arm_data_ready  in  1  outbound data ready
- fpga_to_arm_data  out  1024  outbound data
- mont_start  out  1  Montgomery core start pulse
- mont_a, mont_b, mont_m  out  512 each  operand registers
- mont_done  in  1  core finished, single-cycle pulse
- mont_result  in  512  core result, valid when mont_done=1
- leds  out  4  status: [2:0] state code, [3] error

Function
REQ-002 The FSM SHALL have these states and codes: IDLE=0, RX=1, COMPUTE=2, TX=3, DONE=4.
REQ-003 In IDLE, cmd_valid=1 SHALL decode the opcode:
- 0x1 or 0x2 -> RX
- 0x4 -> COMPUTE
- 0x8 -> TX
- any other opcode -> DONE, with no register change
REQ-004 cmd_valid SHALL be ignored in every state except IDLE.
REQ-005 In RX, arm_to_fpga_data_ready SHALL be 1. A cycle with valid=1 and ready=1 SHALL perform the capture and move to DONE on the next edge:
- opcode 0x1: mont_a <= data[1023:512], mont_b <= data[511:0]
- opcode 0x2: mont_m <= data[511:0]
REQ-006 On entry to COMPUTE, mont_start SHALL be 1 for exactly one cycle. The block SHALL then wait for mont_done.
REQ-007 On mont_done=1 in COMPUTE, the result register SHALL load mont_result and the FSM SHALL go to DONE.
REQ-008 mont_done received outside COMPUTE SHALL be ignored.
REQ-009 In TX, fpga_to_arm_data_valid SHALL be 1 and fpga_to_arm_data SHALL be {512'b0, result}.
REQ-010 In TX, data SHALL stay stable while ready=0. valid=1 and ready=1 SHALL move the FSM to DONE.
REQ-011 In DONE, fpga_to_arm_done SHALL be 1 and SHALL be held until done_read=1. The FSM SHALL then return to IDLE on the next edge.
REQ-012 Minimum latency:
- RX: 1 cycle after the handshake to done=1
- COMPUTE: 1 cycle after mont_done to done=1
- Unknown opcode: done=1 in the cycle after cmd_valid
REQ-013 Operand and result registers SHALL keep their values across commands until overwritten.
REQ-014 data_ready and data_valid SHALL be 0 in every state other than RX and TX respectively.

Reset
REQ-015 resetn=0 SHALL immediately force the FSM to IDLE and clear these to zero: all outputs, mont_a, mont_b, mont_m, result and the error flag.
REQ-016 Reset SHALL abort any command in progress, including mid-COMPUTE and mid-TX, with no done pulse.

Configuration
REQ-017 With macro MONT_TIMEOUT_EN defined:
- A 12-bit counter SHALL clear on entry to COMPUTE and count each COMPUTE cycle.
- If 4095 cycles pass without mont_done, the FSM SHALL go to DONE, leave the result unchanged and set leds[3]=1.
- leds[3] SHALL clear on the next accepted command.
REQ-018 Without MONT_TIMEOUT_EN, COMPUTE SHALL wait indefinitely and leds[3] SHALL be constant 0.

Verification
REQ-019 Cmd 0x1 with data {512'hA5..A5, 512'h3C..3C} -> data_ready=1 in RX, mont_a=A5.., mont_b=3C.., done=1 one cycle after the handshake, then IDLE after done_read.
REQ-020 Cmd 0x2 with data 1024'hF8F6...997D -> mont_m = data[511:0]; mont_a and mont_b unchanged.
REQ-021 Cmd 0x4, model asserts mont_done after 20 cycles with result 512'h1234 -> exactly one mont_start pulse, done=1 on the next cycle; then cmd 0x8 with ready held 0 for 5 cycles -> stable data 1024'h1234, transfer on ready=1, then done.
REQ-022 Cmd 0x4 asserted during COMPUTE and resetn pulsed low mid-COMPUTE -> the second command is ignored; after reset the FSM is IDLE, all outputs are 0 and no done is produced.
REQ-023 Unknown opcode 0x9 -> done=1 the next cycle with no register changes.
REQ-024 With MONT_TIMEOUT_EN defined and the core never responding -> done=1 after 4095 COMPUTE cycles, leds[3]=1, and leds[3]=0 after the next command.
